// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared Y86-64 constants for the fetch/hazard control slice:
// instruction codes, the "no register" id and the sequencer state encodings.
package fetch_pc_ctrl_pkg;

    // Y86-64 instruction codes (icode field)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE   = 4'hF;

    // Fetch sequencer states (visible on state_o)
    localparam logic [1:0] S_RUN      = 2'b00;
    localparam logic [1:0] S_RET_WAIT = 2'b01;
    localparam logic [1:0] S_HALTED   = 2'b10;

    // call and jXX redirect the predicted PC to their constant
    function automatic logic takes_valc(input logic [3:0] icode);
        return (icode == ICALL) || (icode == IJXX);
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_hazard_detect.sv
// Combinational pipeline hazard detection: load/use, ret in flight and
// branch mispredict, folded into the F/D/E stall and bubble controls.
module fetch_pc_ctrl_hazard_detect
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [3:0] d_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] m_icode,
    input  logic       halted,
    output logic       mispred,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble
);

    logic load_use;
    logic ret_haz;

    // Hazard terms and the stall/bubble controls derived from them
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        load_use = ((e_icode == IMRMOVQ) || (e_icode == IPOPQ)) &&
                   (e_dstM != RNONE) &&
                   ((e_dstM == d_srcA) || (e_dstM == d_srcB));
        ret_haz  = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
        mispred  = (e_icode == IJXX) && !e_Cnd;

        F_stall  = load_use | ret_haz | halted;
        D_stall  = load_use;
        // A load/use stall holds D, so the ret bubble must not overwrite it
        D_bubble = mispred | (ret_haz & !load_use);
        E_bubble = mispred | load_use;
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer for the 5-stage Y86-64 core: selects the fetch PC,
// owns the predicted-PC register, tracks ret/halt sequencing and counts
// fetch-stall cycles.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [3:0]        f_icode_i,
    input  logic [ADDR_W-1:0] f_valC_i,
    input  logic [ADDR_W-1:0] f_valP_i,
    input  logic [3:0]        d_icode_i,
    input  logic [3:0]        d_srcA_i,
    input  logic [3:0]        d_srcB_i,
    input  logic [3:0]        e_icode_i,
    input  logic [3:0]        e_dstM_i,
    input  logic              e_Cnd_i,
    input  logic [3:0]        m_icode_i,
    input  logic              m_Cnd_i,
    input  logic [ADDR_W-1:0] m_valA_i,
    input  logic [3:0]        w_icode_i,
    input  logic [ADDR_W-1:0] w_valM_i,
    output logic [ADDR_W-1:0] f_pc_o,
    output logic [ADDR_W-1:0] pred_pc_o,
    output logic              F_stall_o,
    output logic              D_stall_o,
    output logic              D_bubble_o,
    output logic              E_bubble_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [ADDR_W-1:0] pred_pc;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  stall_cnt;

    logic mispred;
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic accept;

    fetch_pc_ctrl_hazard_detect u_hazard_detect (
        .d_icode  (d_icode_i),
        .d_srcA   (d_srcA_i),
        .d_srcB   (d_srcB_i),
        .e_icode  (e_icode_i),
        .e_dstM   (e_dstM_i),
        .e_Cnd    (e_Cnd_i),
        .m_icode  (m_icode_i),
        .halted   (state == S_HALTED),
        .mispred  (mispred),
        .F_stall  (f_stall),
        .D_stall  (d_stall),
        .D_bubble (d_bubble),
        .E_bubble (e_bubble)
    );

    // Pipeline controls are held inactive while reset is asserted
    assign F_stall_o  = rst_n_i & f_stall;
    assign D_stall_o  = rst_n_i & d_stall;
    assign D_bubble_o = rst_n_i & d_bubble;
    assign E_bubble_o = rst_n_i & e_bubble;

    // A fetched instruction only enters D when F is free and D is not being squashed
    assign accept = !f_stall && !mispred;

    // Fetch PC select: mispredict recovery from M, then ret target from W, then prediction
    always_comb begin
        f_pc_o = pred_pc;
        if (!rst_n_i) begin
            f_pc_o = RESET_PC;
        end else if ((m_icode_i == IJXX) && !m_Cnd_i) begin
            f_pc_o = m_valA_i;
        end else if (w_icode_i == IRET) begin
            f_pc_o = w_valM_i;
        end
    end

    // Predicted PC: call/jXX predict their target, everything else falls through
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
        if (!rst_n_i) begin
            pred_pc <= RESET_PC;
        end else if (!f_stall) begin
            pred_pc <= takes_valc(f_icode_i) ? f_valC_i : f_valP_i;
        end
    end

    // Next-state logic; a mispredict suppresses accept, so it wins over ret/halt entry
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (accept && (f_icode_i == IRET)) begin
                    state_nxt = S_RET_WAIT;
                end else if (accept && (f_icode_i == IHALT)) begin
                    state_nxt = S_HALTED;
                end
            end
            S_RET_WAIT: begin
                if (w_icode_i == IRET) begin
                    state_nxt = S_RUN;
                end
            end
            S_HALTED: begin
                // The halt was fetched down a wrong path; recovery resumes fetch
                if (mispred) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else if (f_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign pred_pc_o   = pred_pc;
    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios followed by
// randomized pipeline contents, all compared against a behavioural model.
module tb_fetch_pc_ctrl;
    import fetch_pc_ctrl_pkg::*;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [63:0] RST_PC = 64'h0;

    // Model modes as the spec names them on state_o
    localparam int M_RUN = 0, M_RET_WAIT = 1, M_HALTED = 2;

    logic        clk, rst_n;
    logic [3:0]  f_icode, d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode, w_icode;
    logic [63:0] f_valC, f_valP, m_valA, w_valM;
    logic        e_Cnd, m_Cnd;
    logic [63:0] f_pc, pred_pc;
    logic        F_stall, D_stall, D_bubble, E_bubble;
    logic [1:0]  state;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [63:0] m_pred;
    int          m_mode;
    int          m_cnt;

    fetch_pc_ctrl #(.ADDR_W(64), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .f_icode_i(f_icode), .f_valC_i(f_valC), .f_valP_i(f_valP),
        .d_icode_i(d_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .e_icode_i(e_icode), .e_dstM_i(e_dstM), .e_Cnd_i(e_Cnd),
        .m_icode_i(m_icode), .m_Cnd_i(m_Cnd), .m_valA_i(m_valA),
        .w_icode_i(w_icode), .w_valM_i(w_valM),
        .f_pc_o(f_pc), .pred_pc_o(pred_pc),
        .F_stall_o(F_stall), .D_stall_o(D_stall),
        .D_bubble_o(D_bubble), .E_bubble_o(E_bubble),
        .state_o(state), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Idle pipeline: NOPs everywhere, no registers referenced
    task automatic nop();
        f_icode = INOP; d_icode = INOP; e_icode = INOP; m_icode = INOP; w_icode = INOP;
        d_srcA = RNONE; d_srcB = RNONE; e_dstM = RNONE;
        e_Cnd = 1'b1; m_Cnd = 1'b1;
        f_valC = '0; f_valP = '0; m_valA = '0; w_valM = '0;
    endtask

    task automatic model_reset();
        m_pred = RST_PC;
        m_mode = M_RUN;
        m_cnt  = 0;
    endtask

    // One cycle: check every output against the model, clock, then advance the model.
    // Entered and left 1 time unit after a rising edge.
    task automatic tick();
        bit lu, rh, mp, fs, acc;
        logic [63:0] exp_pc;
        #2;
        lu = (e_icode == IMRMOVQ || e_icode == IPOPQ) && e_dstM != RNONE &&
             (e_dstM == d_srcA || e_dstM == d_srcB);
        rh = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
        mp = (e_icode == IJXX) && !e_Cnd;
        fs = lu || rh || (m_mode == M_HALTED);
        if (m_icode == IJXX && !m_Cnd)  exp_pc = m_valA;
        else if (w_icode == IRET)       exp_pc = w_valM;
        else                            exp_pc = m_pred;

        check("f_pc",      f_pc,      exp_pc);
        check("pred_pc",   pred_pc,   m_pred);
        check("state",     64'(state),     64'(m_mode));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        check("F_stall",   64'(F_stall),   64'(fs));
        check("D_stall",   64'(D_stall),   64'(lu));
        check("D_bubble",  64'(D_bubble),  64'(mp || (rh && !lu)));
        check("E_bubble",  64'(E_bubble),  64'(mp || lu));

        @(posedge clk);
        acc = !fs && !mp;
        if (!fs) m_pred = (f_icode == ICALL || f_icode == IJXX) ? f_valC : f_valP;
        if (m_mode == M_RUN) begin
            if (acc && f_icode == IRET)       m_mode = M_RET_WAIT;
            else if (acc && f_icode == IHALT) m_mode = M_HALTED;
        end else if (m_mode == M_RET_WAIT) begin
            if (w_icode == IRET) m_mode = M_RUN;
        end else if (mp) begin
            m_mode = M_RUN;
        end
        if (fs && m_cnt < CNT_MAX) m_cnt++;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_f_pc"},   f_pc,    RST_PC);
        check({tag, "_pred"},   pred_pc, RST_PC);
        check({tag, "_state"},  64'(state),     64'd0);
        check({tag, "_cnt"},    64'(stall_cnt), 64'd0);
        check({tag, "_ctrl"},   64'({F_stall, D_stall, D_bubble, E_bubble}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        model_reset();
        #3;
        check_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // irmovq fall-through prediction
        nop(); f_icode = IIRMOVQ; f_valP = 64'h0A;
        #1 check("tp_first_pc", f_pc, 64'h0);
        tick();
        check("tp_pred_0a", pred_pc, 64'h0A);

        // load/use: mrmovq into %rax in E, D reads %rax
        nop(); e_icode = IMRMOVQ; e_dstM = 4'h0; d_srcA = 4'h0; f_valP = 64'h14;
        #1 check("tp_lu_ctrl", 64'({F_stall, D_stall, D_bubble, E_bubble}), 64'b1101);
        tick();
        nop(); f_valP = 64'h14;
        #1 check("tp_lu_clear", 64'({F_stall, D_stall, D_bubble, E_bubble}), 64'b0000);
        check("tp_lu_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // jXX predicted taken, then resolved not-taken
        nop(); f_icode = IJXX; f_valC = 64'h40; f_valP = 64'h20;
        tick();
        check("tp_jxx_pred", pred_pc, 64'h40);
        nop(); e_icode = IJXX; e_Cnd = 1'b0;
        #1 check("tp_mp_bub", 64'({D_bubble, E_bubble}), 64'b11);
        tick();
        nop(); m_icode = IJXX; m_Cnd = 1'b0; m_valA = 64'h20; f_valP = 64'h2A;
        #1 check("tp_mp_pc", f_pc, 64'h20);
        tick();

        // ret: wait while it travels D, E, M; resume from W
        nop(); f_icode = IRET; f_valP = 64'h99;
        tick();
        check("tp_ret_wait", 64'(state), 64'd1);
        for (int i = 0; i < 3; i++) begin
            nop();
            if (i == 0) d_icode = IRET; else if (i == 1) e_icode = IRET; else m_icode = IRET;
            #1 check("tp_ret_ctrl", 64'({F_stall, D_bubble}), 64'b11);
            tick();
        end
        nop(); w_icode = IRET; w_valM = 64'h100; f_valP = 64'h10A;
        #1 check("tp_ret_pc", f_pc, 64'h100);
        tick();
        check("tp_ret_run", 64'(state), 64'd0);

        // halt on a wrong path, then recovered by the mispredict
        nop(); f_icode = IHALT;
        tick();
        check("tp_halted", 64'(state), 64'd2);
        nop();
        tick();
        nop(); e_icode = IJXX; e_Cnd = 1'b0;
        tick();
        check("tp_halt_exit", 64'(state), 64'd0);
        nop(); m_icode = IJXX; m_Cnd = 1'b0; m_valA = 64'h77; f_valP = 64'h80;
        #1 check("tp_halt_pc", f_pc, 64'h77);
        tick();

        // ret accept coinciding with a mispredict: no transition
        nop(); f_icode = IRET; e_icode = IJXX; e_Cnd = 1'b0;
        tick();
        check("tp_mp_wins", 64'(state), 64'd0);

        // Randomized pipeline contents
        for (int n = 0; n < 1500; n++) begin
            f_icode = 4'($urandom_range(0, 11));
            d_icode = 4'($urandom_range(0, 11));
            e_icode = 4'($urandom_range(0, 11));
            m_icode = 4'($urandom_range(0, 11));
            w_icode = 4'($urandom_range(0, 11));
            d_srcA  = 4'($urandom_range(0, 15));
            d_srcB  = 4'($urandom_range(0, 15));
            e_dstM  = 4'($urandom_range(0, 15));
            e_Cnd   = 1'($urandom_range(0, 1));
            m_Cnd   = 1'($urandom_range(0, 1));
            f_valC  = {$urandom, $urandom};
            f_valP  = {$urandom, $urandom};
            m_valA  = {$urandom, $urandom};
            w_valM  = {$urandom, $urandom};
            tick();
        end
        check("cnt_saturated", 64'(stall_cnt), 64'(CNT_MAX));

        // Asynchronous reset in the middle of a ret wait with stalls counted
        nop(); f_icode = IRET;
        tick();
        for (int i = 0; i < 2; i++) begin
            nop(); d_icode = IRET;
            tick();
        end
        nop(); m_icode = IJXX; m_Cnd = 1'b0; m_valA = 64'hDEAD;
        e_icode = IMRMOVQ; e_dstM = 4'h3; d_srcB = 4'h3;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
